fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, the program counter width.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, the return-address-stack entry count (power of two, at least 2).
REQ-003 SHALL have parameter RESET_PC, default 0, the PC value loaded at reset.
REQ-004 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address.
- imem_ack  in  1  fetch data valid.
- imem_data  in  16  fetched instruction word.
- instr_valid  out  1  instr/pc valid for decode (one cycle).
- instr  out  16  captured instruction.
- pc  out  PC_W  address of instr.
- jr_en  in  1  jump-register request.
- jr_target  in  PC_W  jump-register target.
- call_en  in  1  call with offset operation[11:0].
- ret_en  in  1  return to RAS top.
- br_en  in  1  conditional branch, offset operation[8:0].
- br_taken  in  1  branch condition true.
- halt_en  in  1  halt request.
- hlt  out  1  processor halted.
- retired  out  32  retired-instruction count.
- ras_ovf  out  1  sticky RAS overflow flag.
- ras_unf  out  1  sticky RAS underflow flag.

Function
REQ-005 SHALL implement the states FETCH, EXEC and HALT.
REQ-006 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc; on imem_ack it SHALL capture imem_data into instr and go to EXEC. Without imem_ack it SHALL hold indefinitely.
REQ-007 In EXEC, the block SHALL drive instr_valid=1 for exactly one cycle and sample the control inputs in that same cycle. It SHALL load the next pc, increment retired, and return to FETCH. The minimum latency is 2 cycles per instruction.
REQ-008 Next-pc priority SHALL be, highest first:
- halt_en: go to HALT, pc unchanged.
- jr_en: jr_target.
- ret_en: RAS top, popped.
- call_en: pc+1+sext(instr[11:0]), pushing pc+1.
- br_en&&br_taken: pc+1+sext(instr[8:0]).
- otherwise: pc+1.
REQ-009 All pc arithmetic SHALL be modulo 2^PC_W; offsets SHALL be sign-extended to PC_W, and the wrap from all-ones to zero is legal.
REQ-010 Control inputs SHALL be ignored outside EXEC; imem_ack SHALL be ignored outside FETCH.
REQ-011 A push when the RAS is full SHALL overwrite the oldest entry (circular) and set ras_ovf.
REQ-012 A pop when the RAS is empty SHALL select pc+1, leave the stack unchanged, and set ras_unf.
REQ-013 The halting instruction SHALL count as retired. In HALT, hlt=1, imem_req=0 and instr_valid=0, and the state SHALL be left only by reset.
REQ-014 retired SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-015 Assertion of rst_n low SHALL immediately force:
- state=FETCH, pc=RESET_PC;
- RAS empty;
- retired=0, hlt=0, ras_ovf=0, ras_unf=0;
- instr=0, instr_valid=0;
- imem_req=0 while reset is held.
REQ-016 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ack SHALL be ignored unless the block is in FETCH after release.
REQ-017 After rst_n deasserts, the block SHALL issue its first request on the next rising edge.

Structure
REQ-018 State encoding and the opcode-field offset widths (12 and 9) SHALL live in the shared cpu package.
REQ-019 The RAS SHALL be a sub-module ras_stack (parameters PC_W and RAS_DEPTH; push, pop, top, full, empty).
REQ-020 All registers SHALL be in the clk/rst_n domain; there SHALL be no latches.

Verification
REQ-021 Sequential fetch: imem_ack held at 1, no controls -> pc runs 0,1,2,3; instr_valid every other cycle; retired=3 after three EXECs.
REQ-022 Call/return: at pc=5, call_en with instr[11:0]=12'h00A -> pc=16; then ret_en -> pc=6, RAS empty.
REQ-023 Backward branch wrap: pc=0, br_en=br_taken=1, instr[8:0]=9'h1FE -> pc=16'hFFFF.
REQ-024 RAS overflow/underflow: 5 calls with RAS_DEPTH=4 -> ras_ovf=1; then 5 returns -> the fifth returns pc+1 and ras_unf=1.
REQ-025 Priority: jr_en, ret_en and call_en asserted together with jr_target=16'h0040 -> pc=16'h0040, RAS unchanged.
REQ-026 Halt and reset: halt_en at pc=7 -> hlt=1, pc stays 7, no further imem_req; then rst_n pulsed low mid-cycle -> outputs immediately reset, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and opcode offset-field widths.
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;
  localparam int CALL_OFF_W = 12;
  localparam int BR_OFF_W = 9;
endpackage

// File: rtl/fetch_sequencer_ras.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int PC_W = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(RAS_DEPTH);
  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [AW-1:0] ptr_q, ptr_inc;
  logic [AW:0] cnt_q;
  assign ptr_inc = ptr_q + 1'b1;
  assign top = mem_q[ptr_q];
  assign full = cnt_q == (AW+1)'(RAS_DEPTH);
  assign empty = cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      ptr_q <= ptr_inc;
      mem_q[ptr_inc] <= push_data;
      cnt_q <= full ? cnt_q : cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: FETCH/EXEC/HALT instruction sequencer with next-pc selection and a return-address stack.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic            instr_valid,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] pc,
  input  logic            jr_en,
  input  logic [PC_W-1:0] jr_target,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic            br_en,
  input  logic            br_taken,
  input  logic            halt_en,
  output logic            hlt,
  output logic [31:0]     retired,
  output logic            ras_ovf,
  output logic            ras_unf
);
  state_e state_q;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, call_tgt, br_tgt, ras_top;
  logic [15:0] instr_q;
  logic [31:0] ret_q;
  logic req_q, ovf_q, unf_q, exec, push, pop, ras_full, ras_empty;
  assign exec = state_q == EXEC;
  assign pc_inc = pc_q + 1'b1;
  assign call_tgt = pc_inc + {{(PC_W-CALL_OFF_W){instr_q[CALL_OFF_W-1]}}, instr_q[CALL_OFF_W-1:0]};
  assign br_tgt = pc_inc + {{(PC_W-BR_OFF_W){instr_q[BR_OFF_W-1]}}, instr_q[BR_OFF_W-1:0]};
  assign pop = exec && !halt_en && !jr_en && ret_en;
  assign push = exec && !halt_en && !jr_en && !ret_en && call_en;
  always_comb pc_d = jr_en ? jr_target :
                     ret_en ? (ras_empty ? pc_inc : ras_top) :
                     call_en ? call_tgt :
                     (br_en && br_taken) ? br_tgt : pc_inc;
  ras_stack #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(pc_inc),
    .top(ras_top), .full(ras_full), .empty(ras_empty)
  );
  // req_q stays low for the first cycle after reset so a stale ack cannot be captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      req_q <= 1'b0;
      instr_q <= '0;
      ret_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && imem_ack) begin
            instr_q <= imem_data;
            req_q <= 1'b0;
            state_q <= EXEC;
          end else req_q <= 1'b1;
        end
        EXEC: begin
          ret_q <= ret_q + {31'd0, ~&ret_q};
          ovf_q <= ovf_q | (push && ras_full);
          unf_q <= unf_q | (pop && ras_empty);
          if (halt_en) state_q <= HALT;
          else begin
            pc_q <= pc_d;
            req_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end
  assign imem_req = req_q;
  assign imem_addr = pc_q;
  assign instr_valid = exec;
  assign instr = instr_q;
  assign pc = pc_q;
  assign hlt = state_q == HALT;
  assign retired = ret_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random checks of fetch_sequencer against an instruction-level model.
module tb_fetch_sequencer;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_ack = 1'b0, instr_valid, hlt, ras_ovf, ras_unf;
  logic [15:0] imem_addr, imem_data = '0, instr, pc, jr_target = '0;
  logic jr_en = 0, call_en = 0, ret_en = 0, br_en = 0, br_taken = 0, halt_en = 0;
  logic [31:0] retired;
  int vectors = 0, miscompares = 0;
  logic [15:0] pc_m;
  logic [15:0] ras_m[$];
  logic ovf_m, unf_m, hlt_m;
  logic [31:0] ret_m;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr_valid(instr_valid), .instr(instr), .pc(pc), .jr_en(jr_en),
    .jr_target(jr_target), .call_en(call_en), .ret_en(ret_en), .br_en(br_en), .br_taken(br_taken),
    .halt_en(halt_en), .hlt(hlt), .retired(retired), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    pc_m = 16'h0000;
    ras_m.delete();
    ovf_m = 0;
    unf_m = 0;
    hlt_m = 0;
    ret_m = 0;
  endtask

  task automatic model_exec(input logic [15:0] d, input logic h, j, r, c, b, t, input logic [15:0] tgt);
    int off;
    ret_m = (ret_m == 32'hFFFF_FFFF) ? ret_m : ret_m + 1;
    if (h) hlt_m = 1;
    else if (j) pc_m = tgt;
    else if (r) begin
      if (ras_m.size() == 0) begin
        unf_m = 1;
        pc_m = pc_m + 16'd1;
      end else pc_m = ras_m.pop_back();
    end else if (c) begin
      if (ras_m.size() == DEPTH) begin
        ovf_m = 1;
        void'(ras_m.pop_front());
      end
      ras_m.push_back(pc_m + 16'd1);
      off = int'(d[11:0]);
      if (off >= 2048) off -= 4096;
      pc_m = 16'(int'(pc_m) + 1 + off);
    end else if (b && t) begin
      off = int'(d[8:0]);
      if (off >= 256) off -= 512;
      pc_m = 16'(int'(pc_m) + 1 + off);
    end else pc_m = pc_m + 16'd1;
  endtask

  task automatic garbage();
    {jr_en, call_en, ret_en, br_en, br_taken, halt_en} = 6'($urandom);
    jr_target = 16'($urandom);
    imem_data = 16'($urandom);
  endtask

  // Called at a negedge; waits for a request, acks it, then drives controls in the EXEC cycle.
  task automatic run_instr(input logic [15:0] d, input logic h, j, r, c, b, t, input logic [15:0] tgt,
                           input int wt, output logic ok, output logic [15:0] ra, output logic v,
                           output logic [15:0] po, output logic [15:0] io, output time tv);
    ok = 0; ra = 'x; v = 'x; po = 'x; io = 'x; tv = 0;
    for (int i = 0; i < wt + 50; i++) begin
      if (imem_req && i >= wt) begin
        ok = 1;
        ra = imem_addr;
        imem_ack = 1;
        imem_data = d;
        break;
      end
      garbage();
      imem_ack = 0;
      @(negedge clk);
    end
    if (!ok) return;
    @(negedge clk);
    v = instr_valid; po = pc; io = instr; tv = $time;
    imem_ack = 1'($urandom);
    imem_data = 16'($urandom);
    {halt_en, jr_en, ret_en, call_en, br_en, br_taken} = {h, j, r, c, b, t};
    jr_target = tgt;
    @(negedge clk);
    {halt_en, jr_en, ret_en, call_en, br_en, br_taken} = '0;
    imem_ack = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    {halt_en, jr_en, ret_en, call_en, br_en, br_taken, imem_ack} = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  logic ok, v;
  logic [15:0] ra, po, io, d;
  time tv, tprev;

  task automatic test_reset();
    #1;
    vectors++;
    if ({imem_req, instr_valid, hlt, pc, retired, instr, ras_ovf, ras_unf} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: req=%b v=%b hlt=%b pc=%h ret=%0d instr=%h ovf=%b unf=%b, want all zero",
               imem_req, instr_valid, hlt, pc, retired, instr, ras_ovf, ras_unf);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h, want 1 0000", imem_req, imem_addr);
    end
    #2 rst_n = 0;
    imem_ack = 1;
    #1;
    vectors++;
    if ({imem_req, pc} !== {1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL req_during_reset: req=%b pc=%h, want 0 0000", imem_req, pc);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    vectors++;
    if ({instr_valid, imem_req} !== 2'b01) begin
      miscompares++;
      $display("FAIL late_ack_ignored: valid=%b req=%b, want 0 1", instr_valid, imem_req);
    end
    imem_ack = 0;
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      d = 16'($urandom);
      run_instr(d, 0, 0, 0, 0, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
      vectors++;
      if ({ok, ra, v, po, io} !== {1'b1, pc_m, 1'b1, pc_m, d}) begin
        miscompares++;
        $display("FAIL seq_instr%0d: ok=%b addr=%h v=%b pc=%h instr=%h, want pc=%h instr=%h", k, ok, ra, v, po, io, pc_m, d);
      end
      if (k > 0) begin
        vectors++;
        if (tv - tprev !== 20) begin
          miscompares++;
          $display("FAIL seq_spacing%0d: %0t between valids, want 20", k, tv - tprev);
        end
      end
      tprev = tv;
      model_exec(d, 0, 0, 0, 0, 0, 0, 16'h0);
      if (k == 2) begin
        vectors++;
        if (retired !== 32'd3) begin
          miscompares++;
          $display("FAIL seq_retired: got %0d, want 3", retired);
        end
      end
    end
  endtask

  task automatic plain(input int n);
    for (int k = 0; k < n; k++) begin
      d = 16'($urandom);
      run_instr(d, 0, 0, 0, 0, 0, 0, 16'h0, int'($urandom_range(0, 2)), ok, ra, v, po, io, tv);
      model_exec(d, 0, 0, 0, 0, 0, 0, 16'h0);
    end
  endtask

  task automatic test_call_ret();
    apply_reset();
    plain(5);
    d = {4'($urandom), 12'h00A};
    run_instr(d, 0, 0, 0, 1, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
    model_exec(d, 0, 0, 0, 1, 0, 0, 16'h0);
    vectors++;
    if ({ok, ra, pc} !== {1'b1, 16'd5, 16'd16}) begin
      miscompares++;
      $display("FAIL call: ok=%b from=%h pc=%h, want from 0005 pc 0010", ok, ra, pc);
    end
    run_instr(16'($urandom), 0, 0, 1, 0, 0, 0, 16'h0, 1, ok, ra, v, po, io, tv);
    model_exec(16'h0, 0, 0, 1, 0, 0, 0, 16'h0);
    vectors++;
    if ({ok, pc, ras_unf} !== {1'b1, 16'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL ret: ok=%b pc=%h unf=%b, want pc 0006 unf 0", ok, pc, ras_unf);
    end
    run_instr(16'($urandom), 0, 0, 1, 0, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
    model_exec(16'h0, 0, 0, 1, 0, 0, 0, 16'h0);
    vectors++;
    if ({ok, pc, ras_unf} !== {1'b1, 16'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL ret_empty: ok=%b pc=%h unf=%b, want pc 0007 unf 1", ok, pc, ras_unf);
    end
  endtask

  task automatic test_branch_wrap();
    apply_reset();
    d = {7'($urandom), 9'h1FE};
    run_instr(d, 0, 0, 0, 0, 1, 1, 16'h0, 0, ok, ra, v, po, io, tv);
    vectors++;
    if ({ok, pc} !== {1'b1, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL br_wrap_back: ok=%b pc=%h, want FFFF", ok, pc);
    end
    run_instr(16'($urandom), 0, 0, 0, 0, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
    vectors++;
    if ({ok, ra, pc} !== {1'b1, 16'hFFFF, 16'h0000}) begin
      miscompares++;
      $display("FAIL pc_wrap_fwd: ok=%b addr=%h pc=%h, want FFFF 0000", ok, ra, pc);
    end
  endtask

  task automatic test_ras_ovf_unf();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      d = 16'($urandom);
      run_instr(d, 0, 0, 0, 1, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
      model_exec(d, 0, 0, 0, 1, 0, 0, 16'h0);
      vectors++;
      if ({ok, pc, ras_ovf} !== {1'b1, pc_m, k == 4}) begin
        miscompares++;
        $display("FAIL ovf_call%0d: ok=%b pc=%h ovf=%b, want pc=%h ovf=%b", k, ok, pc, ras_ovf, pc_m, k == 4);
      end
    end
    for (int k = 0; k < 5; k++) begin
      run_instr(16'($urandom), 0, 0, 1, 0, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
      d = ra + 16'd1;
      model_exec(16'h0, 0, 0, 1, 0, 0, 0, 16'h0);
      vectors++;
      if ({ok, pc, ras_unf} !== {1'b1, pc_m, k == 4}) begin
        miscompares++;
        $display("FAIL unf_ret%0d: ok=%b pc=%h unf=%b, want pc=%h unf=%b", k, ok, pc, ras_unf, pc_m, k == 4);
      end
    end
    vectors++;
    if (pc !== d) begin
      miscompares++;
      $display("FAIL unf_pc_plus1: pc=%h, want %h", pc, d);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    run_instr(16'h0010, 0, 0, 0, 1, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
    run_instr(16'($urandom), 0, 1, 1, 1, 1, 1, 16'h0040, 0, ok, ra, v, po, io, tv);
    vectors++;
    if ({ok, pc} !== {1'b1, 16'h0040}) begin
      miscompares++;
      $display("FAIL prio_jr: ok=%b pc=%h, want 0040", ok, pc);
    end
    run_instr(16'($urandom), 0, 0, 1, 1, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
    vectors++;
    if ({ok, pc, ras_unf} !== {1'b1, 16'h0001, 1'b0}) begin
      miscompares++;
      $display("FAIL prio_ras_kept: ok=%b pc=%h unf=%b, want 0001 0", ok, pc, ras_unf);
    end
    run_instr(16'($urandom), 0, 0, 1, 0, 0, 0, 16'h0, 0, ok, ra, v, po, io, tv);
    vectors++;
    if ({ok, pc, ras_unf} !== {1'b1, 16'h0002, 1'b1}) begin
      miscompares++;
      $display("FAIL prio_ras_empty: ok=%b pc=%h unf=%b, want 0002 1", ok, pc, ras_unf);
    end
  endtask

  task automatic test_halt_reset();
    apply_reset();
    plain(7);
    run_instr(16'($urandom), 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), 0, ok, ra, v, po, io, tv);
    vectors++;
    if ({ok, hlt, pc, retired} !== {1'b1, 1'b1, 16'd7, 32'd8}) begin
      miscompares++;
      $display("FAIL halt: ok=%b hlt=%b pc=%h ret=%0d, want 1 0007 8", ok, hlt, pc, retired);
    end
    for (int k = 0; k < 6; k++) begin
      imem_ack = 1'($urandom);
      garbage();
      @(negedge clk);
      vectors++;
      if ({imem_req, instr_valid, hlt, pc, retired} !== {1'b0, 1'b0, 1'b1, 16'd7, 32'd8}) begin
        miscompares++;
        $display("FAIL halt_hold%0d: req=%b v=%b hlt=%b pc=%h ret=%0d, want 0 0 1 0007 8",
                 k, imem_req, instr_valid, hlt, pc, retired);
      end
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({imem_req, instr_valid, hlt, pc, retired, instr, ras_ovf, ras_unf} !== '0) begin
      miscompares++;
      $display("FAIL halt_async_reset: req=%b v=%b hlt=%b pc=%h ret=%0d instr=%h, want all zero",
               imem_req, instr_valid, hlt, pc, retired, instr);
    end
    {halt_en, jr_en, ret_en, call_en, br_en, br_taken, imem_ack} = '0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL restart_req: req=%b addr=%h, want 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    logic j, r, c, b, t;
    logic [15:0] tgt;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      d = 16'($urandom);
      tgt = 16'($urandom);
      j = $urandom_range(0, 5) == 0;
      r = $urandom_range(0, 3) == 0;
      c = $urandom_range(0, 3) == 0;
      b = $urandom_range(0, 2) == 0;
      t = 1'($urandom);
      run_instr(d, 0, j, r, c, b, t, tgt, int'($urandom_range(0, 3)), ok, ra, v, po, io, tv);
      vectors++;
      if ({ok, ra, v, po, io} !== {1'b1, pc_m, 1'b1, pc_m, d}) begin
        miscompares++;
        $display("FAIL rand_fetch%0d: ok=%b addr=%h v=%b pc=%h instr=%h, want pc=%h instr=%h", k, ok, ra, v, po, io, pc_m, d);
      end
      model_exec(d, 0, j, r, c, b, t, tgt);
      vectors++;
      if ({pc, ras_ovf, ras_unf, hlt, retired} !== {pc_m, ovf_m, unf_m, hlt_m, ret_m}) begin
        miscompares++;
        $display("FAIL rand_state%0d: pc=%h ovf=%b unf=%b hlt=%b ret=%0d, want %h %b %b %b %0d",
                 k, pc, ras_ovf, ras_unf, hlt, retired, pc_m, ovf_m, unf_m, hlt_m, ret_m);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_call_ret();
    test_branch_wrap();
    test_ras_ovf_unf();
    test_priority();
    test_halt_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
